// File: rtl/modn_ripple_free_counter.sv
// Synchronous cascade of NUM_DIGITS modulo-MODULUS digits with up/down, clear,
// range-checked parallel load, combinational terminal count and registered pulses.
module modn_ripple_free_counter #(
    parameter  int MODULUS    = 10,
    parameter  int NUM_DIGITS = 2,
    localparam int DIGIT_W    = ($clog2(MODULUS) < 1) ? 1 : $clog2(MODULUS)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             clear,
    input  logic                             load,
    input  logic [NUM_DIGITS*DIGIT_W-1:0]    load_val,
    input  logic                             en,
    input  logic                             up,
    output logic [NUM_DIGITS*DIGIT_W-1:0]    q,
    output logic                             tc,
    output logic                             wrap,
    output logic                             load_err
);

    localparam int                 QW        = NUM_DIGITS * DIGIT_W;
    localparam logic [DIGIT_W-1:0] DIG_MAX   = DIGIT_W'(MODULUS - 1);
    localparam logic [DIGIT_W:0]   DIG_LIMIT = (DIGIT_W + 1)'(MODULUS);

    logic [QW-1:0]         q_reg;
    logic [QW-1:0]         q_next;
    logic [QW-1:0]         load_fixed;
    logic [NUM_DIGITS-1:0] step_up;
    logic [NUM_DIGITS-1:0] step_dn;
    logic                  all_max;
    logic                  all_zero;
    logic                  load_bad;
    logic                  tc_int;
    logic                  wrap_r;
    logic                  load_err_r;

    // Carry/borrow enables are prefix ANDs over the lower digits, so every
    // digit resolves its step from the current state in the same edge.
    always_comb begin
        logic run_max;
        logic run_zero;
        run_max    = 1'b1;
        run_zero   = 1'b1;
        step_up    = '0;
        step_dn    = '0;
        load_fixed = '0;
        load_bad   = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            step_up[i] = run_max;
            step_dn[i] = run_zero;
            run_max    = run_max  & (q_reg[i*DIGIT_W +: DIGIT_W] == DIG_MAX);
            run_zero   = run_zero & (q_reg[i*DIGIT_W +: DIGIT_W] == '0);
            if ({1'b0, load_val[i*DIGIT_W +: DIGIT_W]} >= DIG_LIMIT)
                load_bad = 1'b1;
            else
                load_fixed[i*DIGIT_W +: DIGIT_W] = load_val[i*DIGIT_W +: DIGIT_W];
        end
        all_max  = run_max;
        all_zero = run_zero;
    end

    always_comb begin
        logic [DIGIT_W-1:0] dig;
        q_next = q_reg;
        dig    = '0;
        if (clear) begin
            q_next = '0;
        end else if (load) begin
            q_next = load_fixed;
        end else if (en) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig = q_reg[i*DIGIT_W +: DIGIT_W];
                if (up && step_up[i])
                    q_next[i*DIGIT_W +: DIGIT_W] = (dig == DIG_MAX) ? '0 : dig + DIGIT_W'(1);
                else if (!up && step_dn[i])
                    q_next[i*DIGIT_W +: DIGIT_W] = (dig == '0) ? DIG_MAX : dig - DIGIT_W'(1);
            end
        end
    end

    assign tc_int = en & ~clear & ~load & (up ? all_max : all_zero);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg      <= '0;
            wrap_r     <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            q_reg      <= q_next;
            wrap_r     <= tc_int;
            load_err_r <= load & ~clear & load_bad;
        end
    end

    assign q        = q_reg;
    assign tc       = tc_int;
    assign wrap     = wrap_r;
    assign load_err = load_err_r;

endmodule

// File: tb/tb_modn_ripple_free_counter.sv
// Bench for modn_ripple_free_counter: an integer-valued model checked every cycle
// for a decimal 2-digit instance and a base-6 3-digit instance, plus directed literals.
module tb_modn_ripple_free_counter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       d_clear, d_load, d_en, d_up;
    logic [7:0] d_load_val, d_q;
    logic       d_tc, d_wrap, d_err;

    logic       a_clear, a_load, a_en, a_up;
    logic [8:0] a_load_val, a_q;
    logic       a_tc, a_wrap, a_err;

    modn_ripple_free_counter #(.MODULUS(10), .NUM_DIGITS(2)) dut_dec (
        .clk(clk), .reset(reset), .clear(d_clear), .load(d_load), .load_val(d_load_val),
        .en(d_en), .up(d_up), .q(d_q), .tc(d_tc), .wrap(d_wrap), .load_err(d_err)
    );

    modn_ripple_free_counter #(.MODULUS(6), .NUM_DIGITS(3)) dut_b6 (
        .clk(clk), .reset(reset), .clear(a_clear), .load(a_load), .load_val(a_load_val),
        .en(a_en), .up(a_up), .q(a_q), .tc(a_tc), .wrap(a_wrap), .load_err(a_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The model holds the count as one integer in 0..MODULUS**NUM_DIGITS-1.
    function automatic longint enc(longint v, int m, int n, int w);
        longint r = 0;
        for (int i = 0; i < n; i++) begin
            r = r | ((v % m) << (i * w));
            v = v / m;
        end
        return r;
    endfunction

    function automatic longint dec_load(logic [63:0] lv, int m, int n, int w);
        longint r = 0;
        longint mult = 1;
        longint dig;
        for (int i = 0; i < n; i++) begin
            dig = longint'((lv >> (i * w)) & ((64'd1 << w) - 1));
            if (dig >= m) dig = 0;
            r = r + dig * mult;
            mult = mult * m;
        end
        return r;
    endfunction

    function automatic bit bad_load(logic [63:0] lv, int m, int n, int w);
        bit b = 0;
        for (int i = 0; i < n; i++)
            if (longint'((lv >> (i * w)) & ((64'd1 << w) - 1)) >= m) b = 1;
        return b;
    endfunction

    function automatic bit tc_model(longint v, longint total, logic en, logic clr, logic ld, logic up);
        return en && !clr && !ld && (up ? (v == total - 1) : (v == 0));
    endfunction

    function automatic longint next_model(longint v, longint total, logic clr, logic ld, longint ldv,
                                          logic en, logic up);
        if (clr) return 0;
        if (ld)  return ldv;
        if (en)  return up ? (v + 1) % total : (v + total - 1) % total;
        return v;
    endfunction

    longint md_v = 0, ma_v = 0;
    logic   md_wrap = 0, md_err = 0, ma_wrap = 0, ma_err = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            md_v = 0; md_wrap = 0; md_err = 0;
            ma_v = 0; ma_wrap = 0; ma_err = 0;
        end else begin
            md_wrap = tc_model(md_v, 100, d_en, d_clear, d_load, d_up);
            md_err  = d_load && !d_clear && bad_load(d_load_val, 10, 2, 4);
            md_v    = next_model(md_v, 100, d_clear, d_load, dec_load(d_load_val, 10, 2, 4), d_en, d_up);
            ma_wrap = tc_model(ma_v, 216, a_en, a_clear, a_load, a_up);
            ma_err  = a_load && !a_clear && bad_load(a_load_val, 6, 3, 3);
            ma_v    = next_model(ma_v, 216, a_clear, a_load, dec_load(a_load_val, 6, 3, 3), a_en, a_up);
        end
    end

    always @(negedge clk) begin
        chk("dec q",        d_q,    enc(md_v, 10, 2, 4));
        chk("dec tc",       d_tc,   tc_model(md_v, 100, d_en, d_clear, d_load, d_up));
        chk("dec wrap",     d_wrap, md_wrap);
        chk("dec load_err", d_err,  md_err);
        chk("b6 q",         a_q,    enc(ma_v, 6, 3, 3));
        chk("b6 tc",        a_tc,   tc_model(ma_v, 216, a_en, a_clear, a_load, a_up));
        chk("b6 wrap",      a_wrap, ma_wrap);
        chk("b6 load_err",  a_err,  ma_err);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int wraps;

    initial begin
        reset = 1'b0;
        d_clear = 0; d_load = 0; d_en = 0; d_up = 0; d_load_val = '0;
        a_clear = 0; a_load = 0; a_en = 0; a_up = 0; a_load_val = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset q",        d_q,    8'h00);
        chk("reset wrap",     d_wrap, 1'b0);
        chk("reset load_err", d_err,  1'b0);
        chk("reset b6 q",     a_q,    9'h000);

        reset = 1'b1; d_en = 1; d_up = 1;
        for (int k = 1; k <= 101; k++) begin
            step();
            if (k == 9)   chk("up 09", d_q, 8'h09);
            if (k == 10)  chk("up 10", d_q, 8'h10);
            if (k == 99) begin
                chk("up 99", d_q, 8'h99);
                chk("tc at 99", d_tc, 1'b1);
            end
            if (k == 100) begin
                chk("up wrap q", d_q, 8'h00);
                chk("up wrap pulse", d_wrap, 1'b1);
                chk("tc at 00", d_tc, 1'b0);
            end
            if (k == 101) begin
                chk("up 01", d_q, 8'h01);
                chk("wrap one cycle", d_wrap, 1'b0);
            end
        end
        repeat (46) step();
        chk("at 47", d_q, 8'h47);
        #2;
        reset = 1'b0;
        #1;
        chk("async reset q",        d_q,    8'h00);
        chk("async reset wrap",     d_wrap, 1'b0);
        chk("async reset load_err", d_err,  1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1; d_en = 1; d_up = 0;

        step(); chk("down 99", d_q, 8'h99); chk("down wrap", d_wrap, 1'b1);
        step(); chk("down 98", d_q, 8'h98); chk("down wrap off", d_wrap, 1'b0);
        d_load = 1; d_load_val = 8'h10;
        step(); chk("load 10", d_q, 8'h10);
        d_load = 0;
        step(); chk("down 09", d_q, 8'h09);

        d_load = 1; d_load_val = 8'h3C;
        step(); chk("load 3C q", d_q, 8'h30); chk("load 3C err", d_err, 1'b1);
        d_load_val = 8'h57;
        step(); chk("load 57 q", d_q, 8'h57); chk("load 57 err", d_err, 1'b0);
        d_clear = 1; d_load_val = 8'h3C;
        step(); chk("clear wins q", d_q, 8'h00); chk("clear wins err", d_err, 1'b0);
        d_clear = 0; d_load_val = 8'hA5;
        step(); chk("load A5 q", d_q, 8'h05); chk("load A5 err", d_err, 1'b1);
        d_load_val = 8'h42;
        step(); chk("load 42", d_q, 8'h42);
        d_load = 0; d_en = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("hold q", d_q, 8'h42);
            chk("hold tc", d_tc, 1'b0);
        end
        d_en = 1; d_up = 1;
        step(); chk("dir 43", d_q, 8'h43);
        d_up = 0;
        step(); chk("dir 42", d_q, 8'h42);
        d_up = 1;
        step(); chk("dir 43b", d_q, 8'h43);
        d_en = 0;

        a_en = 1; a_up = 1; wraps = 0;
        for (int k = 1; k <= 216; k++) begin
            step();
            if (a_wrap) wraps++;
            if (k == 6)   chk("b6 carry 1", a_q, 9'h008);
            if (k == 36)  chk("b6 carry 2", a_q, 9'h040);
            if (k == 215) begin
                chk("b6 max", a_q, 9'h16D);
                chk("b6 tc", a_tc, 1'b1);
            end
            if (k == 216) chk("b6 period", a_q, 9'h000);
        end
        chk("b6 wraps per period", wraps, 1);
        a_en = 0; a_load = 1; a_load_val = 9'h0BC;
        step(); chk("b6 load q", a_q, 9'h084); chk("b6 load err", a_err, 1'b1);
        a_load = 0;
        step(); chk("b6 err one cycle", a_err, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
